mantissa_subtractor48: RTL and testbench

Two-stage pipelined 48-bit mantissa subtractor with valid/ready handshake. It is the subtraction counterpart to the datapath's 48-bit mantissa adder and uses the same operand slice [55:8]. With `ct`=1 it splits into independent 28-bit high and 20-bit low lanes. It returns the sign-magnitude difference (|A−B| plus sign per lane) for effective-subtraction paths in the posit FMA, so no downstream negation stage is needed.

---
 rtl/mantissa_subtractor48.sv | 154 +++++++++++++++
 tb/tb_mantissa_subtractor48.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_subtractor48.sv
// -----------------------------------------------------------------------------
// mantissa_subtractor48
//
// Two-stage pipelined 48-bit mantissa subtractor for the effective-subtraction
// paths of the posit FMA. The result is in sign-magnitude form: |A-B| and a
// sign, so no negation stage is needed downstream. With ct=1 the datapath
// splits into independent 28-bit high [55:28] and 20-bit low [27:8] lanes.
// Each lane then gets its own magnitude and sign.
//
// Stage 1 : low-lane differences (both directions) and borrows, registered
//           together with the high-lane operands and ct.
// Stage 2 : high-lane differences, magnitude select, registered outputs.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle
//   A, B       minuend / subtrahend, bits [55:8]
//   ct         0 = one 48-bit subtraction, 1 = split 28/20-bit lanes
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   diff       magnitude result [55:8]
//   sign_h     ct=0: A<B (48 bits); ct=1: A[55:28]<B[55:28]
//   sign_l     ct=1: A[27:8]<B[27:8]; ct=0: always 0
//   zero       diff == 0
// -----------------------------------------------------------------------------
module mantissa_subtractor48 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [55:8] A,
  input  logic [55:8] B,
  input  logic        ct,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [55:8] diff,
  output logic        sign_h,
  output logic        sign_l,
  output logic        zero
);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic v1, v2;
  logic adv1, adv2, accept;

  assign adv2      = ~v2 | out_ready;
  assign adv1      = v1 & adv2;
  assign in_ready  = ~v1 | adv2;
  assign accept    = in_valid & in_ready;
  assign out_valid = v2;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      // When in_ready is high, slot 1 is either empty or draining into slot 2,
      // so its next occupancy is simply whether a new beat arrives.
      if (in_ready) v1 <= in_valid;
      if (adv2)     v2 <= v1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: low lane
  // ---------------------------------------------------------------------------
  logic [19:0] a_l, b_l;
  logic [19:0] lab_c, lba_c;
  logic        bab_c, bba_c;

  assign a_l   = A[27:8];
  assign b_l   = B[27:8];
  assign lab_c = a_l - b_l;
  assign lba_c = b_l - a_l;
  assign bab_c = (a_l < b_l);
  assign bba_c = (b_l < a_l);

  logic [19:0] s1_lab, s1_lba;
  logic        s1_bab, s1_bba;
  logic [27:0] s1_ah, s1_bh;
  logic        s1_ct;

  // NOTE: pure datapath registers carry no reset; the valid bits alone decide
  // whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_lab <= lab_c;
      s1_lba <= lba_c;
      s1_bab <= bab_c;
      s1_bba <= bba_c;
      s1_ah  <= A[55:28];
      s1_bh  <= B[55:28];
      s1_ct  <= ct;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: high lane and magnitude select
  // ---------------------------------------------------------------------------
  logic        brw_ab, brw_ba;
  logic [28:0] hab_x, hba_x;
  logic [27:0] hab, hba;
  logic        sh;
  logic [19:0] lo_sel;
  logic [27:0] hi_sel;
  logic [55:8] diff_c;
  logic        sign_l_c;

  // The low-lane borrow only ripples into the high lane in full-width mode.
  assign brw_ab = s1_bab & ~s1_ct;
  assign brw_ba = s1_bba & ~s1_ct;

  // One extra bit on the left catches the borrow out of the high lane.
  assign hab_x = {1'b0, s1_ah} - {1'b0, s1_bh} - {28'd0, brw_ab};
  assign hba_x = {1'b0, s1_bh} - {1'b0, s1_ah} - {28'd0, brw_ba};
  assign hab   = hab_x[27:0];
  assign hba   = hba_x[27:0];
  assign sh    = hab_x[28];

  always_comb begin
    hi_sel   = sh ? hba : hab;
    // Full mode: the whole word follows the 48-bit sign.
    // Split mode: the low lane follows its own borrow.
    lo_sel   = sh ? s1_lba : s1_lab;
    sign_l_c = 1'b0;
    if (s1_ct) begin
      lo_sel   = s1_bab ? s1_lba : s1_lab;
      sign_l_c = s1_bab;
    end
    diff_c = {hi_sel, lo_sel};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff   <= '0;
      sign_h <= 1'b0;
      sign_l <= 1'b0;
    end else if (adv1) begin
      diff   <= diff_c;
      sign_h <= sh;
      sign_l <= sign_l_c;
    end
  end

  // Derived from the registered magnitude, so it reads 1 straight out of reset.
  assign zero = (diff == '0);

endmodule

// File: tb/tb_mantissa_subtractor48.sv
// -----------------------------------------------------------------------------
// tb_mantissa_subtractor48
//
// Scoreboard bench for mantissa_subtractor48. The driver pushes the expected
// {diff, sign_h, sign_l, zero} for every accepted beat. A monitor pops and
// compares on every output transfer, and checks that outputs hold while
// stalled. Random beats use an arithmetic reference model. Directed beats use
// hand-derived constants.
// -----------------------------------------------------------------------------
module tb_mantissa_subtractor48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [55:8] A = '0;
  logic [55:8] B = '0;
  logic        ct = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [55:8] diff;
  logic        sign_h, sign_l, zero;

  mantissa_subtractor48 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ct        (ct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .sign_h    (sign_h),
    .sign_l    (sign_l),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_out  = 0;

  logic [50:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain magnitude/sign arithmetic on the operand values.
  function automatic logic [50:0] model(input logic [47:0] a, input logic [47:0] b,
                                        input logic c);
    logic [47:0] d;
    logic        sh, sl;
    if (!c) begin
      sh = (a < b);
      sl = 1'b0;
      d  = sh ? (b - a) : (a - b);
    end else begin
      sh = (a[47:20] < b[47:20]);
      sl = (a[19:0]  < b[19:0]);
      d[47:20] = sh ? (b[47:20] - a[47:20]) : (a[47:20] - b[47:20]);
      d[19:0]  = sl ? (b[19:0]  - a[19:0])  : (a[19:0]  - b[19:0]);
    end
    return {d, sh, sl, (d == 48'd0)};
  endfunction

  // Present one beat, wait (bounded) for acceptance, record its expectation.
  task automatic issue(input logic [47:0] a, input logic [47:0] b, input logic c,
                       input logic [50:0] exp);
    int  t;
    bit  done;
    t    = 0;
    done = 0;
    A = a; B = b; ct = c; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        n_acc++;
        done = 1;
      end else if (++t > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic issue_m(input logic [47:0] a, input logic [47:0] b, input logic c);
    issue(a, b, c, model(a, b, c));
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_outputs",   {13'd0, diff, sign_h, sign_l, zero}, {13'd0, 48'd0, 3'b001});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [50:0] prev_out;
  bit          prev_stall = 0;

  always @(negedge clk) begin
    logic [50:0] cur;
    cur = {diff, sign_h, sign_l, zero};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && out_valid)
        check("hold_stable", {13'd0, cur}, {13'd0, prev_out});
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_nonempty", {63'd0, (sb.size() != 0)}, 64'd1);
        if (sb.size() != 0) check("result", {13'd0, cur}, {13'd0, sb.pop_front()});
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit rand_done = 0;

  initial begin
    logic [63:0] r1, r2;
    logic [47:0] ra, rb;
    int          base, t;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();
    @(posedge clk); #1;

    // Directed beats with hand-derived expectations.
    issue(48'h000000_000005, 48'h000000_000003, 1'b0, {48'h2, 3'b000});
    issue(48'h000000_100000, 48'h000000_100001, 1'b0, {48'h1, 3'b100});
    issue(48'h000001_000000, 48'h000000_F00001, 1'b0, {48'h0F_FFFF, 3'b000});
    issue({28'h1, 20'h0},    {28'h1, 20'h1},    1'b1, {48'h1, 3'b010});
    issue({28'h1, 20'h0},    {28'h1, 20'h1},    1'b0, {48'h1, 3'b100});
    issue(48'hABCDEF_123456, 48'hABCDEF_123456, 1'b0, {48'h0, 3'b001});
    issue(48'hABCDEF_123456, 48'hABCDEF_123456, 1'b1, {48'h0, 3'b001});
    // Split mode, high lane negative and low lane positive.
    issue({28'h2, 20'h5},    {28'h7, 20'h3},    1'b1, {28'h5, 20'h2, 3'b100});
    repeat (4) @(posedge clk); #1;

    // Backpressure: 2 accepts fill both slots, outputs hold, release streams.
    out_ready = 1'b0;
    base = n_acc;
    fork
      for (int i = 0; i < 6; i++) issue(48'(100 + i), 48'd0, 1'b0, {48'(100 + i), 3'b000});
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_accepts",   64'(n_acc - base), 64'd2);
        check("bp_in_ready",  {63'd0, in_ready},  64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_beat0",     {16'd0, diff},      64'd100);
        @(posedge clk); #1;
        out_ready = 1'b1;
        t = n_out;
        repeat (6) @(posedge clk);
        #2 check("bp_throughput", 64'(n_out - t), 64'd6);
      end
    join
    repeat (3) @(posedge clk); #1;

    // Reset with both slots occupied.
    out_ready = 1'b0;
    issue_m(48'h123, 48'h456, 1'b0);
    issue_m(48'h789, 48'h012, 1'b1);
    @(negedge clk);
    check("pre_rst_full", {62'd0, in_ready, out_valid}, 64'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check_reset_state();
    @(posedge clk); #1;
    issue_m(48'h0000_0001_0000, 48'h0000_0000_FFFF, 1'b0);
    issue_m(48'h0000_0000_0003, 48'h0000_0010_0000, 1'b1);
    repeat (4) @(posedge clk); #1;

    // Random beats with random gaps and random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          r1 = {$urandom, $urandom};
          r2 = {$urandom, $urandom};
          ra = r1[47:0];
          rb = r2[47:0];
          case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb[47:20] = ra[47:20];
            2: rb[19:0]  = ra[19:0];
            default: ;
          endcase
          issue_m(ra, rb, 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 1)) @(posedge clk);
          #1;
        end
        rand_done = 1;
      end
      while (!rand_done) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join

    // Drain.
    out_ready = 1'b1;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
